// File: rtl/rom_arbiter.sv
// Two-port read arbiter in front of the synchronous 1Kx8 program ROM; routes each
// one-cycle-latency return to its requester. Define ROM_ARB_ROUND_ROBIN_EN for round-robin.
//
// pending tag | meaning
// TAG_NONE    | no read issued last cycle, nothing returns now
// TAG_P0      | port 0 was granted last cycle, rom_data belongs to port 0
// TAG_P1      | port 1 was granted last cycle, rom_data belongs to port 1
module rom_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0,
    input  logic [9:0] addr0,
    output logic       ack0,
    output logic       valid0,
    output logic [7:0] data0,
    input  logic       req1,
    input  logic [9:0] addr1,
    output logic       ack1,
    output logic       valid1,
    output logic [7:0] data1,
    output logic [9:0] rom_address,
    input  logic [7:0] rom_data
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_P0   = 2'b01,
        TAG_P1   = 2'b10
    } tag_t;

    tag_t       tag_q;
    tag_t       tag_d;
    logic       grant0;
    logic       grant1;
    logic [9:0] addr_q;
    logic [7:0] hold0_q;
    logic [7:0] hold1_q;

`ifdef ROM_ARB_ROUND_ROBIN_EN
    logic last_p1_q;

    // On a tie the port that did not win most recently takes the ROM.
    always_comb begin
        grant0 = req0 && (!req1 || last_p1_q);
        grant1 = req1 && (!req0 || !last_p1_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_p1_q <= 1'b1;
        end else if (ack0) begin
            last_p1_q <= 1'b0;
        end else if (ack1) begin
            last_p1_q <= 1'b1;
        end
    end
`else
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starve_q;
    logic       starve_hit;

    // Port 0 normally wins; a saturated starvation count hands port 1 the ROM.
    always_comb begin
        starve_hit = (starve_q == LIMIT);
        grant1     = req1 && (!req0 || starve_hit);
        grant0     = req0 && !grant1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_q <= 8'd0;
        end else if (!req1 || ack1) begin
            starve_q <= 8'd0;
        end else if (!starve_hit) begin
            starve_q <= starve_q + 8'd1;
        end
    end
`endif

    // Acks are forced low while reset is held, even with requests pending.
    always_comb begin
        ack0 = grant0 && reset_n;
        ack1 = grant1 && reset_n;
    end

    always_comb begin
        if (ack0) begin
            rom_address = addr0;
        end else if (ack1) begin
            rom_address = addr1;
        end else begin
            rom_address = addr_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= 10'd0;
        end else if (ack0 || ack1) begin
            addr_q <= rom_address;
        end
    end

    // Pending-tag FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_q <= TAG_NONE;
        end else begin
            tag_q <= tag_d;
        end
    end

    // Pending-tag FSM: next state
    always_comb begin
        tag_d = TAG_NONE;
        if (ack0) begin
            tag_d = TAG_P0;
        end else if (ack1) begin
            tag_d = TAG_P1;
        end
    end

    // Pending-tag FSM: outputs
    always_comb begin
        valid0 = (tag_q == TAG_P0);
        valid1 = (tag_q == TAG_P1);
        data0  = valid0 ? rom_data : hold0_q;
        data1  = valid1 ? rom_data : hold1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold0_q <= 8'd0;
            hold1_q <= 8'd0;
        end else begin
            if (tag_q == TAG_P0) begin
                hold0_q <= rom_data;
            end
            if (tag_q == TAG_P1) begin
                hold1_q <= rom_data;
            end
        end
    end

endmodule
